// File: rtl/cpu_pkg.sv
// Shared CPU constants: branch condition codes and flag bit positions.
// The instruction decoder and the assembler use the same values.
package cpu_pkg;

  // Branch condition codes (4-bit field of the branch instruction)
  localparam logic [3:0] COND_EQ   = 4'd0;
  localparam logic [3:0] COND_NE   = 4'd1;
  localparam logic [3:0] COND_PL   = 4'd2;
  localparam logic [3:0] COND_MI   = 4'd3;
  localparam logic [3:0] COND_CS   = 4'd4;
  localparam logic [3:0] COND_CC   = 4'd5;
  localparam logic [3:0] COND_VS   = 4'd6;
  localparam logic [3:0] COND_VC   = 4'd7;
  localparam logic [3:0] COND_HI   = 4'd8;
  localparam logic [3:0] COND_LS   = 4'd9;
  localparam logic [3:0] COND_GE   = 4'd10;
  localparam logic [3:0] COND_LT   = 4'd11;
  localparam logic [3:0] COND_GT   = 4'd12;
  localparam logic [3:0] COND_LE   = 4'd13;
  localparam logic [3:0] COND_AL   = 4'd14;
  localparam logic [3:0] COND_DBNZ = 4'd15;

  // Bit positions inside the packed {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage : cpu_pkg

// File: rtl/loop_counter.sv
// Hardware loop counter for decrement-and-branch-if-nonzero.
// A load wins over a decrement; the decrement saturates at zero.
module loop_counter #(
  parameter int LC_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [LC_W-1:0] data_i,
  input  logic            dec_i,
  output logic [LC_W-1:0] cnt_o,
  output logic            zero_o,
  output logic            gt1_o
);

  localparam logic [LC_W-1:0] ONE = {{(LC_W-1){1'b0}}, 1'b1};

  logic [LC_W-1:0] cnt_q;
  logic [LC_W-1:0] cnt_d;
  logic            zero_s;

  assign zero_s = (cnt_q == {LC_W{1'b0}});

  // Next count: load has priority, decrement only while nonzero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = data_i;
    end else if (dec_i && !zero_s) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {LC_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = zero_s;
  assign gt1_o  = (cnt_q > ONE);

endmodule : loop_counter

// File: rtl/branch_cond_unit.sv
// Branch-condition unit: registered NZCV flags with same-cycle bypass,
// 16-way condition evaluation, DBNZ loop counter and optional output stage.
module branch_cond_unit
  import cpu_pkg::*;
#(
  parameter int LC_W    = 8,
  parameter int BS_W    = 4,
  parameter int REG_OUT = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Z,
  input  logic            N,
  input  logic            C,
  input  logic            V,
  input  logic            FLAG_WE,
  input  logic            BR_EN,
  input  logic [BS_W-1:0] BS,
  input  logic            LC_LOAD,
  input  logic [LC_W-1:0] LC_DATA,
  output logic            MP,
  output logic [3:0]      FLAGS,
  output logic [LC_W-1:0] LC,
  output logic            LC_ZERO
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic [3:0] live_flags_s;
  logic [3:0] eff_flags_s;
  logic [3:0] code_s;
  logic       bs_hi_s;
  logic       cond_s;
  logic       taken_s;
  logic       dbnz_dec_s;
  logic       lc_gt1_s;
  logic       z_s;
  logic       n_s;
  logic       c_s;
  logic       v_s;

  assign live_flags_s = {N, Z, C, V};
  assign code_s       = BS[3:0];

  // Any select bit above the 4-bit code field makes the branch not-taken
  generate
    if (BS_W > 4) begin : g_bs_wide
      assign bs_hi_s = |BS[BS_W-1:4];
    end else begin : g_bs_narrow
      assign bs_hi_s = 1'b0;
    end
  endgenerate

  // Flag register next state: load on FLAG_WE, otherwise hold
  always_comb begin
    flags_d = flags_q;
    if (FLAG_WE) begin
      flags_d = live_flags_s;
    end else begin
      flags_d = flags_q;
    end
  end

  // Flag register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Bypass hides the flag-register latency from the branch decision
  assign eff_flags_s = FLAG_WE ? live_flags_s : flags_q;
  assign n_s = eff_flags_s[FLAG_N];
  assign z_s = eff_flags_s[FLAG_Z];
  assign c_s = eff_flags_s[FLAG_C];
  assign v_s = eff_flags_s[FLAG_V];

  // Condition evaluation on the effective flags and pre-load loop count
  always_comb begin
    cond_s = 1'b0;
    case (code_s)
      COND_EQ:   cond_s = z_s;
      COND_NE:   cond_s = !z_s;
      COND_PL:   cond_s = !n_s;
      COND_MI:   cond_s = n_s;
      COND_CS:   cond_s = c_s;
      COND_CC:   cond_s = !c_s;
      COND_VS:   cond_s = v_s;
      COND_VC:   cond_s = !v_s;
      COND_HI:   cond_s = c_s & !z_s;
      COND_LS:   cond_s = !c_s | z_s;
      COND_GE:   cond_s = (n_s == v_s);
      COND_LT:   cond_s = (n_s != v_s);
      COND_GT:   cond_s = !z_s & (n_s == v_s);
      COND_LE:   cond_s = z_s | (n_s != v_s);
      COND_AL:   cond_s = 1'b1;
      COND_DBNZ: cond_s = lc_gt1_s;
      default:   cond_s = 1'b0;
    endcase
  end

  assign taken_s = BR_EN & !bs_hi_s & cond_s;

  // A load in the same cycle suppresses the DBNZ decrement
  assign dbnz_dec_s = BR_EN & !bs_hi_s & (code_s == COND_DBNZ) & !LC_LOAD;

  loop_counter #(
    .LC_W (LC_W)
  ) u_loop_counter (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (LC_LOAD),
    .data_i (LC_DATA),
    .dec_i  (dbnz_dec_s),
    .cnt_o  (LC),
    .zero_o (LC_ZERO),
    .gt1_o  (lc_gt1_s)
  );

  generate
    if (REG_OUT != 0) begin : g_mp_reg
      logic mp_q;

      // One-cycle output stage for the taken decision
      always_ff @(posedge CLK) begin
        if (RST) begin
          mp_q <= 1'b0;
        end else begin
          mp_q <= taken_s;
        end
      end

      // Reset forces not-taken even while the stage still holds a decision
      assign MP = mp_q & !RST;
    end else begin : g_mp_comb
      assign MP = taken_s & !RST;
    end
  endgenerate

  assign FLAGS = flags_q;

endmodule : branch_cond_unit

// File: doc/branch_cond_unit.md
# branch_cond_unit

Parametrised branch-condition unit for the single-cycle CPU, successor to the four-condition branch mux. It holds a registered NZCV flag set with same-cycle bypass, evaluates 16 branch conditions (legacy Z/NZ/PL/MI codes unchanged), and owns a hardware loop counter for decrement-and-branch-if-nonzero (DBNZ). It sits between the ALU flag outputs and the PC-select mux, producing the taken signal MP.

## Interface
- LC_W, 8: loop-counter width, 2..32.
- BS_W, 4: branch-select width, ≥4; codes ≥16 evaluate not-taken.
- REG_OUT, 0: 0 = MP combinational; 1 = MP registered, one-cycle latency.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- Z, N, C, V  in  1 each  live ALU flags for this cycle.
- FLAG_WE  in  1  capture Z/N/C/V into the flag register.
- BR_EN  in  1  current instruction is a conditional branch.
- BS  in  BS_W  condition select.
- LC_LOAD  in  1  load the loop counter from LC_DATA.
- LC_DATA  in  LC_W  loop-counter load value.
- MP  out  1  branch taken.
- FLAGS  out  4  registered {N,Z,C,V}.
- LC  out  LC_W  loop-counter value.
- LC_ZERO  out  1  LC == 0.

## Operation
- Effective flags: the live Z/N/C/V inputs when FLAG_WE=1, else the registered flags (bypass).
- Condition codes (z, n, c, v = effective flags):
  - 0 EQ: z.
  - 1 NE: !z.
  - 2 PL: !n.
  - 3 MI: n.
  - 4 CS: c.
  - 5 CC: !c.
  - 6 VS: v.
  - 7 VC: !v.
  - 8 HI: c&!z.
  - 9 LS: !c|z.
  - 10 GE: n==v.
  - 11 LT: n!=v.
  - 12 GT: !z&(n==v).
  - 13 LE: z|(n!=v).
  - 14 AL: 1.
  - 15 DBNZ: LC>1.
  - Codes ≥16: 0.
- taken = BR_EN & cond(BS). BR_EN=0 gives taken=0 for every code.
- Flag register: FLAG_WE=1 loads {N,Z,C,V}; otherwise it holds.
- Loop counter:
  - LC_LOAD=1: LC←LC_DATA. Takes priority over a DBNZ decrement in the same cycle.
  - BR_EN=1, BS=15, LC≠0, no load: LC←LC−1.
  - LC=0: DBNZ leaves LC at 0 (saturates, no wrap to all-ones) and is not taken.
  - DBNZ in the same cycle as LC_LOAD: taken is evaluated on the pre-load LC.
- Reset: flags ← 0000, LC ← 0, registered MP ← 0. While RST=1, MP=0 in both modes and no state updates. Reset applied mid-loop abandons the count.

## Timing
- REG_OUT=0: MP is valid in the same cycle as BR_EN/BS. Combinational path from Z/N/C/V through the bypass to MP.
- REG_OUT=1: MP reflects the previous cycle's taken; the first cycle after reset gives MP=0.
- FLAGS and LC update on the edge after their enables. The bypass makes the FLAGS register latency invisible to MP.
- FLAG_WE, LC_LOAD and a DBNZ may all occur in one cycle; each follows its rule above independently.

## Structure
- A shared package (cpu_pkg) holds:
  - the condition-code constants COND_EQ..COND_DBNZ (4-bit);
  - the flag bit indices FLAG_N/Z/C/V.
- Decoder and assembler use the same constants.
- One natural sub-module: loop_counter (load, saturating decrement, zero flag, parameter LC_W).
- Flag register, bypass, condition evaluation and the REG_OUT stage stay in the top module.

## Test plan
- Legacy codes: flags Z=1,N=0 registered, BR_EN=1.
  - BS=0 → MP=1; BS=1 → 0; BS=2 → 1; BS=3 → 0.
  - BR_EN=0 → MP=0 for all BS.
- Bypass: register holds Z=0; same cycle FLAG_WE=1 with Z=1, BS=0, BR_EN=1.
  - MP=1 that cycle.
  - FLAGS reads Z=1 the next cycle.
- Signed conditions:
  - N=1,V=0 → LT=1, GE=0, LE=1, GT=0.
  - N=1,V=1,Z=0 → GT=1.
  - C=1,Z=0 → HI=1; C=1,Z=1 → LS=1.
- DBNZ loop: LC_LOAD with 3, then three DBNZ cycles.
  - MP=1,1,0; LC=2,1,0.
  - A fourth DBNZ gives MP=0, LC stays 0.
  - LC_LOAD=5 together with DBNZ at LC=1: MP=0, LC=5.
- REG_OUT=1, BS=14, BR_EN pulsed one cycle: MP=1 exactly one cycle later.
- Reset mid-operation: RST during a loop with LC=7, flags 1111.
  - Next cycle FLAGS=0000, LC=0, LC_ZERO=1.
  - MP=0 throughout the reset.
- BS_W=5, BS=16..31 with BR_EN=1: MP=0 for all.
